game_phase_controller: RTL and testbench

- Top-level sequencer for one round of the counting game: IDLE -> prelim countdown -> game period -> result display -> next level or back to idle.
- Drives prelimSig into the prelim-period block and consumes its gameSig completion.
- Tracks curLevel and times the game period and result hold.
- Selects which source owns the four 7-segment digits in each phase.

---
 rtl/game_phase_controller_pkg.sv | 32 +++
 rtl/game_phase_controller_tick_sync.sv | 23 ++
 rtl/game_phase_controller.sv | 113 +++++++++++
 tb/tb_game_phase_controller.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/game_phase_controller_pkg.sv
// game_phase_controller_pkg: phase encoding, segment constants and digit lookup shared by the phase blocks
package game_phase_controller_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRELIM    = 3'd1,
        GAME      = 3'd2,
        WIN_SHOW  = 3'd3,
        LOSE_SHOW = 3'd4,
        VICTORY   = 3'd5
    } phase_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_DP    = 8'h7F;

    // active-low {dp,g,f,e,d,c,b,a}; out-of-range values show blank
    function automatic logic [7:0] digit_seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return SEG_BLANK;
        endcase
    endfunction
endpackage

// File: rtl/game_phase_controller_tick_sync.sv
// tick_sync: two-flop synchronizer plus registered rising-edge detect, one-cycle tick per input rise
module tick_sync (
    input  logic Clk100M,
    input  logic resetN,
    input  logic sigIn,
    output logic tick
);
    logic s1, s2, s3;

    always_ff @(posedge Clk100M) begin
        if (!resetN) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            tick <= 1'b0;
        end else begin
            s1   <= sigIn;
            s2   <= s1;
            s3   <= s2;
            tick <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/game_phase_controller.sv
// game_phase_controller: round sequencer (idle, prelim, game, result, victory) with level tracking and display select
module game_phase_controller
    import game_phase_controller_pkg::*;
#(
    parameter int MAX_LEVEL      = 9,
    parameter int START_LEVEL    = 1,
    parameter int GAME_SECONDS   = 30,
    parameter int RESULT_SECONDS = 3
) (
    input  logic       Clk100M,
    input  logic       resetN,
    input  logic       Clk1Hz,
    input  logic       startBtn,
    input  logic       gameSig,
    input  logic       roundWin,
    input  logic       roundLose,
    input  logic [7:0] prelimSeg0,
    input  logic [7:0] prelimSeg1,
    input  logic [7:0] prelimSeg2,
    input  logic [7:0] prelimSeg3,
    input  logic [7:0] gameSeg0,
    input  logic [7:0] gameSeg1,
    input  logic [7:0] gameSeg2,
    input  logic [7:0] gameSeg3,
    output logic       prelimSig,
    output logic       gameEnable,
    output logic [3:0] curLevel,
    output logic [2:0] phase,
    output logic [7:0] seg0,
    output logic [7:0] seg1,
    output logic [7:0] seg2,
    output logic [7:0] seg3
);
    phase_t      state;
    logic        tick, gameSigD, gameRise, gameDone, resultDone;
    logic [4:0]  secCnt;
    logic [31:0] disp;

    tick_sync u_tick (
        .Clk100M (Clk100M),
        .resetN  (resetN),
        .sigIn   (Clk1Hz),
        .tick    (tick)
    );

    assign gameRise   = gameSig & ~gameSigD;
    assign gameDone   = tick && secCnt == 5'(GAME_SECONDS - 1);
    assign resultDone = tick && secCnt == 5'(RESULT_SECONDS - 1);
    assign phase      = state;

    always_comb begin
        disp = state == PRELIM   ? {prelimSeg3, prelimSeg2, prelimSeg1, prelimSeg0} :
               state == GAME     ? {gameSeg3, gameSeg2, gameSeg1, gameSeg0} :
               state == WIN_SHOW ? {SEG_BLANK, SEG_BLANK, SEG_BLANK, digit_seg(curLevel)} :
               state == VICTORY  ? {4{SEG_DP}} : {4{SEG_DASH}};
    end

    always_ff @(posedge Clk100M) begin
        gameSigD <= gameSig;
        if (!resetN) begin
            state      <= IDLE;
            curLevel   <= 4'(START_LEVEL);
            prelimSig  <= 1'b0;
            gameEnable <= 1'b0;
            secCnt     <= '0;
            {seg3, seg2, seg1, seg0} <= {4{SEG_BLANK}};
        end else begin
            {seg3, seg2, seg1, seg0} <= disp;
            if (tick && secCnt != '1)
                secCnt <= secCnt + 5'd1;
            case (state)
                IDLE: if (startBtn) begin
                    state     <= PRELIM;
                    prelimSig <= 1'b1;
                    secCnt    <= '0;
                end
                PRELIM: if (gameRise) begin
                    state      <= GAME;
                    prelimSig  <= 1'b0;
                    gameEnable <= 1'b1;
                    secCnt     <= '0;
                end
                GAME: if (roundWin || roundLose || gameDone) begin
                    state      <= roundWin ? WIN_SHOW : LOSE_SHOW;
                    gameEnable <= 1'b0;
                    secCnt     <= '0;
                end
                WIN_SHOW: if (resultDone) begin
                    secCnt <= '0;
                    if (curLevel >= 4'(MAX_LEVEL)) begin
                        state <= VICTORY;
                    end else begin
                        state     <= PRELIM;
                        prelimSig <= 1'b1;
                        curLevel  <= curLevel + 4'd1;
                    end
                end
                LOSE_SHOW: if (resultDone) begin
                    state    <= IDLE;
                    curLevel <= 4'(START_LEVEL);
                    secCnt   <= '0;
                end
                VICTORY: if (startBtn) begin
                    state     <= PRELIM;
                    prelimSig <= 1'b1;
                    curLevel  <= 4'(START_LEVEL);
                    secCnt    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_game_phase_controller.sv
// tb_game_phase_controller: directed scenario tasks for game_phase_controller
module tb_game_phase_controller;
    logic       Clk100M = 1'b0, resetN = 1'b0, Clk1Hz = 1'b0;
    logic       startBtn = 1'b0, gameSig = 1'b0, roundWin = 1'b0, roundLose = 1'b0;
    logic [7:0] prelimSeg0 = 8'h11, prelimSeg1 = 8'h22, prelimSeg2 = 8'h33, prelimSeg3 = 8'h44;
    logic [7:0] gameSeg0 = 8'h55, gameSeg1 = 8'h66, gameSeg2 = 8'h77, gameSeg3 = 8'h88;
    logic       prelimSig, gameEnable;
    logic [3:0] curLevel;
    logic [2:0] phase;
    logic [7:0] seg0, seg1, seg2, seg3;
    int checks = 0, failures = 0;

    game_phase_controller dut (
        .Clk100M(Clk100M), .resetN(resetN), .Clk1Hz(Clk1Hz), .startBtn(startBtn),
        .gameSig(gameSig), .roundWin(roundWin), .roundLose(roundLose),
        .prelimSeg0(prelimSeg0), .prelimSeg1(prelimSeg1), .prelimSeg2(prelimSeg2), .prelimSeg3(prelimSeg3),
        .gameSeg0(gameSeg0), .gameSeg1(gameSeg1), .gameSeg2(gameSeg2), .gameSeg3(gameSeg3),
        .prelimSig(prelimSig), .gameEnable(gameEnable), .curLevel(curLevel), .phase(phase),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3)
    );

    always #5 Clk100M = ~Clk100M;

    task automatic step();
        @(negedge Clk100M);
    endtask

    // 4 cycles high covers synchronizer, tick register and the state update
    task automatic pulse_tick();
        Clk1Hz = 1'b1;
        repeat (4) step();
        Clk1Hz = 1'b0;
        repeat (4) step();
    endtask

    task automatic pulse_game();
        gameSig = 1'b1;
        step();
        gameSig = 1'b0;
        step();
    endtask

    task automatic pulse_win();
        roundWin = 1'b1;
        step();
        roundWin = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) step();
        resetN = 1'b1;
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        checks++; if (curLevel !== 4'd1) begin failures++; $display("FAIL reset_level got=%0d exp=1", curLevel); end
        checks++; if (prelimSig !== 1'b0 || gameEnable !== 1'b0) begin failures++; $display("FAIL reset_ctl got=%b%b exp=00", prelimSig, gameEnable); end
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_seg got=%h exp=ffffffff", {seg3, seg2, seg1, seg0}); end
        step();
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hBFBFBFBF) begin failures++; $display("FAIL idle_seg got=%h exp=bfbfbfbf", {seg3, seg2, seg1, seg0}); end
    endtask

    task automatic test_start();
        gameSig = 1'b1;
        step();
        startBtn = 1'b1;
        step();
        startBtn = 1'b0;
        checks++; if (phase !== 3'd1 || prelimSig !== 1'b1) begin failures++; $display("FAIL start_prelim got=%0d/%b exp=1/1", phase, prelimSig); end
        step();
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'h44332211) begin failures++; $display("FAIL prelim_seg got=%h exp=44332211", {seg3, seg2, seg1, seg0}); end
        checks++; if (curLevel !== 4'd1) begin failures++; $display("FAIL prelim_level got=%0d exp=1", curLevel); end
        repeat (3) step();
        checks++; if (phase !== 3'd1) begin failures++; $display("FAIL held_gamesig got=%0d exp=1", phase); end
        gameSig = 1'b0;
        step();
    endtask

    task automatic test_game_entry();
        gameSig = 1'b1;
        step();
        gameSig = 1'b0;
        checks++; if (phase !== 3'd2 || prelimSig !== 1'b0 || gameEnable !== 1'b1) begin failures++; $display("FAIL game_entry got=%0d/%b%b exp=2/01", phase, prelimSig, gameEnable); end
        step();
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'h88776655) begin failures++; $display("FAIL game_seg got=%h exp=88776655", {seg3, seg2, seg1, seg0}); end
        startBtn = 1'b1;
        step();
        startBtn = 1'b0;
        checks++; if (phase !== 3'd2) begin failures++; $display("FAIL start_ignored got=%0d exp=2", phase); end
    endtask

    task automatic test_win();
        pulse_win();
        checks++; if (phase !== 3'd3 || gameEnable !== 1'b0) begin failures++; $display("FAIL win_phase got=%0d/%b exp=3/0", phase, gameEnable); end
        step();
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFFFFF9) begin failures++; $display("FAIL win_seg got=%h exp=fffffff9", {seg3, seg2, seg1, seg0}); end
        pulse_tick();
        pulse_tick();
        checks++; if (phase !== 3'd3) begin failures++; $display("FAIL win_hold got=%0d exp=3", phase); end
        pulse_tick();
        checks++; if (phase !== 3'd1 || curLevel !== 4'd2 || prelimSig !== 1'b1) begin failures++; $display("FAIL win_advance got=%0d/%0d/%b exp=1/2/1", phase, curLevel, prelimSig); end
    endtask

    task automatic test_timeout();
        pulse_game();
        for (int i = 0; i < 29; i++) pulse_tick();
        checks++; if (phase !== 3'd2) begin failures++; $display("FAIL before_timeout got=%0d exp=2", phase); end
        pulse_tick();
        checks++; if (phase !== 3'd4 || gameEnable !== 1'b0) begin failures++; $display("FAIL timeout got=%0d/%b exp=4/0", phase, gameEnable); end
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hBFBFBFBF) begin failures++; $display("FAIL lose_seg got=%h exp=bfbfbfbf", {seg3, seg2, seg1, seg0}); end
        pulse_tick();
        pulse_tick();
        checks++; if (phase !== 3'd4) begin failures++; $display("FAIL lose_hold got=%0d exp=4", phase); end
        pulse_tick();
        checks++; if (phase !== 3'd0 || curLevel !== 4'd1) begin failures++; $display("FAIL lose_idle got=%0d/%0d exp=0/1", phase, curLevel); end
    endtask

    task automatic test_simultaneous();
        startBtn = 1'b1;
        step();
        startBtn = 1'b0;
        pulse_game();
        roundWin = 1'b1;
        roundLose = 1'b1;
        step();
        roundWin = 1'b0;
        roundLose = 1'b0;
        checks++; if (phase !== 3'd3) begin failures++; $display("FAIL win_beats_lose got=%0d exp=3", phase); end
        repeat (3) pulse_tick();
        checks++; if (phase !== 3'd1 || curLevel !== 4'd2) begin failures++; $display("FAIL simul_advance got=%0d/%0d exp=1/2", phase, curLevel); end
    endtask

    task automatic test_victory();
        for (int l = 2; l < 9; l++) begin
            pulse_game();
            pulse_win();
            repeat (3) pulse_tick();
        end
        checks++; if (phase !== 3'd1 || curLevel !== 4'd9) begin failures++; $display("FAIL reach_level9 got=%0d/%0d exp=1/9", phase, curLevel); end
        pulse_game();
        pulse_win();
        step();
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFFFF90) begin failures++; $display("FAIL win9_seg got=%h exp=ffffff90", {seg3, seg2, seg1, seg0}); end
        repeat (3) pulse_tick();
        checks++; if (phase !== 3'd5 || curLevel !== 4'd9) begin failures++; $display("FAIL victory got=%0d/%0d exp=5/9", phase, curLevel); end
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'h7F7F7F7F) begin failures++; $display("FAIL victory_seg got=%h exp=7f7f7f7f", {seg3, seg2, seg1, seg0}); end
        startBtn = 1'b1;
        step();
        startBtn = 1'b0;
        checks++; if (phase !== 3'd1 || curLevel !== 4'd1 || prelimSig !== 1'b1) begin failures++; $display("FAIL victory_restart got=%0d/%0d/%b exp=1/1/1", phase, curLevel, prelimSig); end
    endtask

    task automatic test_reset_mid();
        pulse_game();
        checks++; if (phase !== 3'd2) begin failures++; $display("FAIL mid_game got=%0d exp=2", phase); end
        resetN = 1'b0;
        step();
        resetN = 1'b1;
        checks++; if (phase !== 3'd0 || gameEnable !== 1'b0 || curLevel !== 4'd1) begin failures++; $display("FAIL mid_reset got=%0d/%b/%0d exp=0/0/1", phase, gameEnable, curLevel); end
        checks++; if ({seg3, seg2, seg1, seg0} !== 32'hFFFFFFFF) begin failures++; $display("FAIL mid_reset_seg got=%h exp=ffffffff", {seg3, seg2, seg1, seg0}); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_game_entry();
        test_win();
        test_timeout();
        test_simultaneous();
        test_victory();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
